// File: rtl/core_pipe_mem.sv
`default_nettype none
// ============================================================================
//  Module      : core_pipe_mem
//  Description : Memory-request stage feeding writeback; issues dmem requests,
//                builds strobes/lane data and registers the s3 payload.
//                Optional misaligned-access trapping: CORE_MISALIGN_TRAP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_pipe_mem #(
    parameter int XLEN       = 64,
    parameter int MEM_ADDR_W = 64
) (
    input  logic                  g_clk,
    input  logic                  g_reset,

    input  logic                  s2_valid,
    output logic                  s2_ready,
    input  logic [XLEN-1:0]       s2_pc,
    input  logic [XLEN-1:0]       s2_n_pc,
    input  logic [31:0]           s2_instr,
    input  logic [XLEN-1:0]       s2_addr,
    input  logic [XLEN-1:0]       s2_sdata,
    input  logic [4:0]            s2_rd,
    input  logic [4:0]            s2_lsu_op,
    input  logic [2:0]            s2_csr_op,
    input  logic [11:0]           s2_csr_addr,
    input  logic [3:0]            s2_cfu_op,
    input  logic [1:0]            s2_wb_op,
    input  logic                  s2_trap,

    input  logic                  flush,

    output logic                  s3_valid,
    input  logic                  s3_ready,
    output logic                  s3_full,
    output logic [XLEN-1:0]       s3_pc,
    output logic [XLEN-1:0]       s3_n_pc,
    output logic [31:0]           s3_instr,
    output logic [XLEN-1:0]       s3_wdata,
    output logic [4:0]            s3_rd,
    output logic [4:0]            s3_lsu_op,
    output logic [2:0]            s3_csr_op,
    output logic [11:0]           s3_csr_addr,
    output logic [3:0]            s3_cfu_op,
    output logic [1:0]            s3_wb_op,
    output logic                  s3_trap,

    output logic                  dmem_req,
    output logic [MEM_ADDR_W-1:0] dmem_addr,
    output logic                  dmem_wen,
    output logic [7:0]            dmem_strb,
    output logic [63:0]           dmem_wdata,
    input  logic                  dmem_gnt
);

    // lsu_op layout: [0] load, [1] store, [3:2] size (byte/half/word/double), [4] unsigned
    localparam int         c_LSU_LOAD          = 0;
    localparam int         c_LSU_STORE         = 1;
    localparam logic [4:0] c_CAUSE_LD_MISALIGN = 5'd4;
    localparam logic [4:0] c_CAUSE_ST_MISALIGN = 5'd6;
    localparam logic [1:0] c_WB_OP_NONE        = 2'b00;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_e;

    state_e                r_state;
    state_e                w_state_nxt;
    logic                  r_flush_seen;

    logic [MEM_ADDR_W-1:0] r_hold_addr;
    logic                  r_hold_wen;
    logic [7:0]            r_hold_strb;
    logic [63:0]           r_hold_wdata;

    logic                  w_mem_op;
    logic [1:0]            w_size;
    logic [2:0]            w_off;
    logic                  w_mis;
    logic                  w_mis_trap;
    logic                  w_issue;
    logic                  w_mem_path;
    logic [7:0]            w_size_mask;
    logic [7:0]            w_strb;
    logic [63:0]           w_sdata64;
    logic [63:0]           w_wdata;
    logic [MEM_ADDR_W-1:0] w_addr_ext;
    logic [MEM_ADDR_W-1:0] w_addr_al;
    logic                  w_dmem_req;
    logic                  w_s2_ready;
    logic                  w_accept;

    assign w_mem_op = s2_lsu_op[c_LSU_LOAD] | s2_lsu_op[c_LSU_STORE];
    assign w_size   = s2_lsu_op[3:2];
    assign w_off    = s2_addr[2:0];

`ifdef CORE_MISALIGN_TRAP_EN
    logic w_mis_raw;
    always_comb begin
        w_mis_raw = 1'b0;
        case (w_size)
            2'd0:    w_mis_raw = 1'b0;
            2'd1:    w_mis_raw = w_off[0];
            2'd2:    w_mis_raw = |w_off[1:0];
            default: w_mis_raw = |w_off;
        endcase
    end
    assign w_mis = w_mem_op & w_mis_raw;
`else
    assign w_mis = 1'b0;
`endif

    assign w_mis_trap = w_mis & ~s2_trap;
    assign w_mem_path = w_mem_op & ~s2_trap & ~w_mis;
    assign w_issue    = s2_valid & w_mem_path & ~flush;

    always_comb begin
        w_size_mask = 8'h01;
        case (w_size)
            2'd0:    w_size_mask = 8'h01;
            2'd1:    w_size_mask = 8'h03;
            2'd2:    w_size_mask = 8'h0F;
            default: w_size_mask = 8'hFF;
        endcase
    end

    // Strobe bits pushed past lane 7 fall off the 8-bit result.
    assign w_strb     = w_size_mask << w_off;
    assign w_sdata64  = 64'(s2_sdata);
    assign w_wdata    = w_sdata64 << {w_off, 3'b000};
    assign w_addr_ext = MEM_ADDR_W'(s2_addr);
    assign w_addr_al  = w_addr_ext & ~(MEM_ADDR_W'(7));

    always_comb begin
        w_state_nxt = r_state;
        w_dmem_req  = 1'b0;
        w_s2_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_dmem_req = w_issue & s3_ready;
                if (w_mem_path)
                    w_s2_ready = s3_ready & dmem_gnt & w_dmem_req & ~flush;
                else
                    w_s2_ready = s3_ready & ~flush;
                if (w_dmem_req && !dmem_gnt)
                    w_state_nxt = ST_REQ;
            end
            ST_REQ: begin
                // Locked request: a flushed instruction still waits for its grant.
                w_dmem_req = 1'b1;
                w_s2_ready = s3_ready & dmem_gnt & ~r_flush_seen & ~flush;
                if (dmem_gnt)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_accept   = s2_valid & w_s2_ready;
    assign s2_ready   = w_s2_ready;
    assign s3_valid   = w_accept;
    assign dmem_req   = w_dmem_req & ~g_reset;
    assign dmem_addr  = (r_state == ST_REQ) ? r_hold_addr  : w_addr_al;
    assign dmem_wen   = (r_state == ST_REQ) ? r_hold_wen   : s2_lsu_op[c_LSU_STORE];
    assign dmem_strb  = (r_state == ST_REQ) ? r_hold_strb  : w_strb;
    assign dmem_wdata = (r_state == ST_REQ) ? r_hold_wdata : w_wdata;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_state      <= ST_IDLE;
            r_flush_seen <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_wen   <= 1'b0;
            r_hold_strb  <= '0;
            r_hold_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_REQ) begin
                if (dmem_gnt)
                    r_flush_seen <= 1'b0;
                else if (flush)
                    r_flush_seen <= 1'b1;
            end else begin
                r_flush_seen <= 1'b0;
            end
            if (r_state == ST_IDLE) begin
                r_hold_addr  <= w_addr_al;
                r_hold_wen   <= s2_lsu_op[c_LSU_STORE];
                r_hold_strb  <= w_strb;
                r_hold_wdata <= w_wdata;
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            s3_full     <= 1'b0;
            s3_pc       <= '0;
            s3_n_pc     <= '0;
            s3_instr    <= '0;
            s3_wdata    <= '0;
            s3_rd       <= '0;
            s3_lsu_op   <= '0;
            s3_csr_op   <= '0;
            s3_csr_addr <= '0;
            s3_cfu_op   <= '0;
            s3_wb_op    <= c_WB_OP_NONE;
            s3_trap     <= 1'b0;
        end else if (w_accept) begin
            s3_full     <= 1'b1;
            s3_pc       <= s2_pc;
            s3_n_pc     <= s2_n_pc;
            s3_instr    <= s2_instr;
            s3_wdata    <= s2_addr;
            s3_csr_op   <= s2_csr_op;
            s3_csr_addr <= s2_csr_addr;
            s3_cfu_op   <= s2_cfu_op;
            s3_wb_op    <= s2_wb_op;
            s3_trap     <= s2_trap | w_mis_trap;
            if (w_mis_trap) begin
                s3_rd     <= s2_lsu_op[c_LSU_LOAD] ? c_CAUSE_LD_MISALIGN : c_CAUSE_ST_MISALIGN;
                s3_lsu_op <= '0;
            end else begin
                s3_rd     <= s2_rd;
                s3_lsu_op <= s2_lsu_op;
            end
        end else if (s3_ready || flush) begin
            s3_full <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_pipe_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_pipe_mem
//  Description : Directed self-checking bench for core_pipe_mem.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_pipe_mem;

    logic        g_clk;
    logic        g_reset;
    logic        s2_valid;
    logic        s2_ready;
    logic [63:0] s2_pc, s2_n_pc, s2_addr, s2_sdata;
    logic [31:0] s2_instr;
    logic [4:0]  s2_rd, s2_lsu_op;
    logic [2:0]  s2_csr_op;
    logic [11:0] s2_csr_addr;
    logic [3:0]  s2_cfu_op;
    logic [1:0]  s2_wb_op;
    logic        s2_trap;
    logic        flush;
    logic        s3_valid, s3_ready, s3_full;
    logic [63:0] s3_pc, s3_n_pc, s3_wdata;
    logic [31:0] s3_instr;
    logic [4:0]  s3_rd, s3_lsu_op;
    logic [2:0]  s3_csr_op;
    logic [11:0] s3_csr_addr;
    logic [3:0]  s3_cfu_op;
    logic [1:0]  s3_wb_op;
    logic        s3_trap;
    logic        dmem_req, dmem_wen, dmem_gnt;
    logic [63:0] dmem_addr, dmem_wdata;
    logic [7:0]  dmem_strb;

    int n_vec = 0;
    int n_err = 0;

    // lsu_op encodings: {unsigned, size[1:0], store, load}
    localparam logic [4:0] c_LW = 5'b01001;
    localparam logic [4:0] c_LD = 5'b01101;
    localparam logic [4:0] c_SB = 5'b00010;
    localparam logic [4:0] c_SD = 5'b01110;

    core_pipe_mem #(.XLEN(64), .MEM_ADDR_W(64)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .s2_valid(s2_valid), .s2_ready(s2_ready),
        .s2_pc(s2_pc), .s2_n_pc(s2_n_pc), .s2_instr(s2_instr),
        .s2_addr(s2_addr), .s2_sdata(s2_sdata), .s2_rd(s2_rd),
        .s2_lsu_op(s2_lsu_op), .s2_csr_op(s2_csr_op), .s2_csr_addr(s2_csr_addr),
        .s2_cfu_op(s2_cfu_op), .s2_wb_op(s2_wb_op), .s2_trap(s2_trap),
        .flush(flush),
        .s3_valid(s3_valid), .s3_ready(s3_ready), .s3_full(s3_full),
        .s3_pc(s3_pc), .s3_n_pc(s3_n_pc), .s3_instr(s3_instr),
        .s3_wdata(s3_wdata), .s3_rd(s3_rd), .s3_lsu_op(s3_lsu_op),
        .s3_csr_op(s3_csr_op), .s3_csr_addr(s3_csr_addr), .s3_cfu_op(s3_cfu_op),
        .s3_wb_op(s3_wb_op), .s3_trap(s3_trap),
        .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wen(dmem_wen),
        .dmem_strb(dmem_strb), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        g_reset = 1'b1; s2_valid = 1'b0; s2_pc = 64'h100; s2_n_pc = 64'h104;
        s2_instr = 32'h13; s2_addr = 64'h1004; s2_sdata = '0; s2_rd = 5'd1;
        s2_lsu_op = c_LW; s2_csr_op = '0; s2_csr_addr = '0; s2_cfu_op = '0;
        s2_wb_op = 2'b10; s2_trap = 1'b0; flush = 1'b0; s3_ready = 1'b1; dmem_gnt = 1'b0;

        // Reset state, with a valid load presented to check request gating
        s2_valid = 1'b1;
        tick(); tick();
        chk("rst_s3_full", s3_full, 0);
        chk("rst_wb_op", s3_wb_op, 0);
        chk("rst_trap", s3_trap, 0);
        chk("rst_lsu_op", s3_lsu_op, 0);
        chk("rst_dmem_req", dmem_req, 0);
        s2_valid = 1'b0; g_reset = 1'b0;
        tick();

        // LW 0x1004 granted in the same cycle
        s2_valid = 1'b1; s2_lsu_op = c_LW; s2_addr = 64'h1004; dmem_gnt = 1'b1;
        #1;
        chk("lw_req", dmem_req, 1);
        chk("lw_addr", dmem_addr, 64'h1000);
        chk("lw_strb", dmem_strb, 8'hF0);
        chk("lw_wen", dmem_wen, 0);
        chk("lw_s3_valid", s3_valid, 1);
        tick();
        chk("lw_s3_full", s3_full, 1);
        chk("lw_s3_wdata", s3_wdata, 64'h1004);
        chk("lw_s3_lsu", s3_lsu_op, c_LW);
        s2_valid = 1'b0; dmem_gnt = 1'b0;

        // SB 0xAB at 0x2003, grant 3 cycles late
        s2_valid = 1'b1; s2_lsu_op = c_SB; s2_addr = 64'h2003; s2_sdata = 64'hAB;
        #1;
        chk("sb_req0", dmem_req, 1);
        chk("sb_strb0", dmem_strb, 8'h08);
        chk("sb_wdata0", dmem_wdata, 64'h0000_0000_AB00_0000);
        chk("sb_wen0", dmem_wen, 1);
        chk("sb_ready0", s2_ready, 0);
        tick();
        chk("sb_s3_cleared", s3_full, 0);
        s3_ready = 1'b0; s2_addr = 64'h5555_5550;
        #1;
        chk("sb_req1", dmem_req, 1);
        chk("sb_addr1_held", dmem_addr, 64'h2000);
        chk("sb_strb1_held", dmem_strb, 8'h08);
        chk("sb_ready1", s2_ready, 0);
        tick();
        s3_ready = 1'b1; s2_addr = 64'h2003;
        #1;
        chk("sb_req2", dmem_req, 1);
        chk("sb_ready2", s2_ready, 0);
        tick();
        dmem_gnt = 1'b1;
        #1;
        chk("sb_req3", dmem_req, 1);
        chk("sb_ready3", s2_ready, 1);
        chk("sb_wdata3", dmem_wdata, 64'h0000_0000_AB00_0000);
        tick();
        chk("sb_s3_full", s3_full, 1);
        chk("sb_s3_wdata", s3_wdata, 64'h2003);
        s2_valid = 1'b0; dmem_gnt = 1'b0;
        #1;
        chk("sb_req_done", dmem_req, 0);

        // Flush while the request is locked, grant two cycles later
        s2_valid = 1'b1; s2_lsu_op = c_LD; s2_addr = 64'h4000;
        #1;
        chk("fl_req0", dmem_req, 1);
        tick();
        flush = 1'b1;
        #1;
        chk("fl_ready_flush", s2_ready, 0);
        chk("fl_req_flush", dmem_req, 1);
        tick();
        flush = 1'b0; s2_valid = 1'b0; s2_addr = 64'h9998;
        #1;
        chk("fl_req_hold", dmem_req, 1);
        chk("fl_addr_hold", dmem_addr, 64'h4000);
        tick();
        dmem_gnt = 1'b1;
        #1;
        chk("fl_gnt_req", dmem_req, 1);
        chk("fl_gnt_ready", s2_ready, 0);
        chk("fl_gnt_s3v", s3_valid, 0);
        tick();
        chk("fl_s3_full", s3_full, 0);
        s2_valid = 1'b1; s2_lsu_op = c_LW; s2_addr = 64'h1008;
        #1;
        chk("fl_next_ready", s2_ready, 1);
        chk("fl_next_addr", dmem_addr, 64'h1008);
        tick();
        chk("fl_next_full", s3_full, 1);
        chk("fl_next_wdata", s3_wdata, 64'h1008);
        s2_valid = 1'b0; dmem_gnt = 1'b0;

        // LD at 0x3004 (misaligned doubleword)
        s2_valid = 1'b1; s2_lsu_op = c_LD; s2_addr = 64'h3004;
`ifdef CORE_MISALIGN_TRAP_EN
        #1;
        chk("mis_no_req", dmem_req, 0);
        chk("mis_ready", s2_ready, 1);
        tick();
        chk("mis_trap", s3_trap, 1);
        chk("mis_cause", s3_rd, 5'd4);
        chk("mis_lsu", s3_lsu_op, 0);
`else
        dmem_gnt = 1'b1;
        #1;
        chk("mis_req", dmem_req, 1);
        chk("mis_addr", dmem_addr, 64'h3000);
        chk("mis_strb", dmem_strb, 8'hF0);
        tick();
        chk("mis_trap", s3_trap, 0);
        chk("mis_lsu", s3_lsu_op, c_LD);
`endif
        s2_valid = 1'b0; dmem_gnt = 1'b0;

        // Upstream trap on a load: no request, cause passed through
        s2_valid = 1'b1; s2_lsu_op = c_LW; s2_addr = 64'h1000; s2_trap = 1'b1; s2_rd = 5'd2;
        #1;
        chk("utrap_no_req", dmem_req, 0);
        chk("utrap_ready", s2_ready, 1);
        tick();
        chk("utrap_s3_trap", s3_trap, 1);
        chk("utrap_s3_rd", s3_rd, 5'd2);
        s2_trap = 1'b0; s2_valid = 1'b0;

        // Back-to-back ADDs, then one blocked by flush
        s2_valid = 1'b1; s2_lsu_op = 5'b0; s2_wb_op = 2'b01; s2_rd = 5'd3; s2_addr = 64'h11;
        #1;
        chk("add0_s3v", s3_valid, 1);
        chk("add0_no_req", dmem_req, 0);
        tick();
        chk("add0_wdata", s3_wdata, 64'h11);
        chk("add0_rd", s3_rd, 5'd3);
        s2_rd = 5'd4; s2_addr = 64'h22;
        #1;
        chk("add1_s3v", s3_valid, 1);
        tick();
        chk("add1_wdata", s3_wdata, 64'h22);
        chk("add1_rd", s3_rd, 5'd4);
        chk("add1_wb_op", s3_wb_op, 2'b01);
        flush = 1'b1;
        #1;
        chk("add_flush_ready", s2_ready, 0);
        tick();
        chk("add_flush_full", s3_full, 0);
        flush = 1'b0; s2_valid = 1'b0;

        // Reset while a store request is waiting for its grant
        s2_valid = 1'b1; s2_lsu_op = c_SD; s2_addr = 64'h6000; s2_sdata = 64'h1234;
        #1;
        chk("rq_req", dmem_req, 1);
        tick();
        g_reset = 1'b1; s2_valid = 1'b0;
        tick();
        g_reset = 1'b0;
        #1;
        chk("rq_req_dropped", dmem_req, 0);
        chk("rq_s3_full", s3_full, 0);
        s2_valid = 1'b1; s2_lsu_op = c_LW; s2_addr = 64'h7000; dmem_gnt = 1'b1;
        #1;
        chk("rq_idle_addr", dmem_addr, 64'h7000);
        chk("rq_idle_ready", s2_ready, 1);
        tick();
        chk("rq_idle_wdata", s3_wdata, 64'h7000);
        s2_valid = 1'b0; dmem_gnt = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
